// File: rtl/inv_key_schedule_if.sv
// inv_key_schedule_if: start/key request plus valid/ready round-key stream.
interface inv_key_schedule_if #(parameter int nk = 4);
  logic start;
  logic [32*nk-1:0] last_key;
  logic rk_valid;
  logic rk_ready;
  logic [127:0] rk_data;
  logic [3:0] rk_round;
  logic rk_last;
  logic busy;
  modport master(output start, last_key, rk_ready, input rk_valid, rk_data, rk_round, rk_last, busy);
  modport slave(input start, last_key, rk_ready, output rk_valid, rk_data, rk_round, rk_last, busy);
endinterface

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: runs the AES key schedule backwards over an nk-word window, streaming round keys nr..0.
module inv_key_schedule #(
  parameter int nk = 4,
  parameter int nb = 4,
  parameter int nr = 10
) (
  input logic clk,
  input logic rst_n,
  inv_key_schedule_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT, STEP} state_t;
  state_t state;
  logic [32*nk-1:0] win;
  logic [5:0] j, i, off;
  logic [3:0] r;
  logic [31:0] prev, t;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction
  function automatic logic [7:0] rcon(input logic [5:0] k);
    logic [7:0] c;
    c = 8'h01;
    for (int n = 1; n < 10; n++) c = (6'(n) < k) ? {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00) : c;
    return c;
  endfunction
  assign i = j + 6'(nk - 1);
  assign off = {r, 2'b00} - j;
  assign prev = win[32*(nk-2) +: 32];
  always_comb begin
    t = (6'(i % nk) == 6'd0) ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon(6'(i / nk)), 24'h0}
      : ((nk > 6) && 6'(i % nk) == 6'd4) ? sub_word(prev) : prev;
  end
  assign bus.rk_valid = state == EMIT;
  assign bus.busy = state != IDLE;
  assign bus.rk_round = r;
  assign bus.rk_last = bus.rk_valid && r == 4'd0;
  assign bus.rk_data = bus.rk_valid ? 128'(win >> {off, 5'b0}) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      win <= '0;
      j <= '0;
      r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          win <= bus.last_key;
          j <= 6'(nb * (nr + 1) - nk);
          r <= 4'(nr);
          state <= EMIT;
        end
        EMIT: if (bus.rk_ready) begin
          if (r == 4'd0) state <= IDLE;
          else begin
            r <= r - 4'd1;
            state <= (j <= {r - 4'd1, 2'b00}) ? EMIT : STEP;
          end
        end
        STEP: begin
          // recovered word w[j-1] enters at the bottom, w[j+nk-1] falls off the top
          win <= {win[32*(nk-1)-1:0], win[32*(nk-1) +: 32] ^ t};
          j <= j - 6'd1;
          state <= (j - 6'd1 <= {r, 2'b00}) ? EMIT : STEP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Sequential AES round-key generator for the decryption datapath.
- Takes the last nk words of an expanded key schedule and runs the key schedule backwards, one word per cycle.
- Streams round keys nr, nr-1, … 0 over a valid/ready interface, so the inverse cipher can consume them in the order it needs.
- Replaces storing the full nb*(nr+1)-word schedule with an nk-word sliding window.

Parameters:
- nk, 4, key length in 32-bit words (4/6/8 → AES-128/192/256).
- nb, 4, block size in words; fixed at 4.
- nr, 10, number of rounds (10/12/14, must match nk).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- last_key  input  32*nk  {w[N-1],…,w[N-nk]}, N=nb*(nr+1); word w[N-nk] in the LSBs (same packing as the forward expanded-key bus).
- rk_valid  output  1  round key present on rk_data.
- rk_ready  input  1  consumer accepts when rk_valid&rk_ready.
- rk_data  output  128  {w[4r+3],w[4r+2],w[4r+1],w[4r]} for round r.
- rk_round  output  4  round index r of rk_data.
- rk_last  output  1  high with rk_valid when r==0.
- busy  output  1  high from the cycle after start is accepted until the round-0 handshake completes.

Behaviour:
- Reset (asynchronous, any state): FSM→IDLE; rk_valid=0, rk_last=0, busy=0, rk_data=0, rk_round=0; window cleared.
- State: window of nk words holding w[j..j+nk-1]; j is a 6-bit word index; r is a 4-bit round counter.
- IDLE, start=1:
  - Capture last_key into the window.
  - j←N-nk, r←nr, busy←1, next state EMIT.
  - start is ignored in every other state.
- EMIT:
  - rk_valid=1; rk_data is window words at offsets 4r-j .. 4r-j+3; rk_round=r; rk_last=(r==0).
  - rk_data, rk_round and rk_last are held stable while rk_ready=0.
  - On handshake with r==0: IDLE; busy=0 and rk_valid=0 in the next cycle.
  - On handshake with r>0: r←r-1; next state is EMIT if j≤4(r-1), else STEP.
- STEP (one word per cycle, rk_valid=0), with i=j+nk-1:
  - If i%nk==0: t=SubWord(RotWord(w[i-1]))^Rcon(i/nk).
  - Else if nk>6 and i%nk==4: t=SubWord(w[i-1]).
  - Else: t=w[i-1].
  - w[j-1]=w[i]^t. The window shifts up: new word enters at the bottom, w[i] is discarded; j←j-1.
  - Next state is EMIT if j-1≤4r, else STEP.
- Rcon(k), placed in the MSB byte: 01,02,04,08,10,20,40,80,1b,36 for k=1..10.
- RotWord: {a[23:0],a[31:24]}. SubWord applies the shared AES forward S-box function to each byte (four combinational instances).
- Timing, rk_ready tied high, AES-128: start at cycle 0; round 10 valid at cycle 1; each later round key valid 5 cycles after the previous one; round 0 at cycle 51.
- AES-256: rounds 14 and 13 are emitted back-to-back without a STEP between them.
- Consumer stall: the FSM stays in EMIT and no STEP executes, so no key is lost.
- rk_ready high while rk_valid=0 has no effect.
- Reset mid-run: all progress aborts; a new start is required.

Test Plan:
- AES-128, last_key=128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8, rk_ready=1 → rk_round 10 data=128'hb6630ca6e13f0cc8c9ee2589d014f9a8 at cycle 1; round 9 data=128'h575c006e28d1294119fadc21ac7766f3; round 0 data=128'h09cf4f3cabf7158828aed2a62b7e1516 with rk_last=1 at cycle 51; busy falls at cycle 52.
- Same key, rk_ready randomly deasserted (≥50%) → rk_data/rk_round stable during every stall; sequence of 11 keys identical to the previous test; no duplicates or skips.
- nk=8, nr=14, last_key=w[52..59] taken from the forward expansion of 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10 → rounds 14 and 13 in consecutive handshake cycles; every round r matches forward w[4r..4r+3]; round 0 equals the key's low 128 bits (128'h857d77812b73aef015ca71be603deb10).
- nk=6, nr=12, random 192-bit key → 13 keys in order 12..0; each matches the forward-expansion model; round 12 emitted one cycle after start.
- rst_n pulsed low during the AES-128 run at round 5 EMIT → outputs go to 0 asynchronously; busy=0; a new start then yields the full 10..0 sequence correctly.
- start asserted repeatedly while busy → ignored; sequence and busy timing unchanged.
